// File: rtl/store_request_unit_pkg.sv
// Shared store-side definitions: store-type encodings and the request FSM states.
package store_defs;

    // Store types as presented by the execute stage; encodings 101..111 are undefined.
    typedef enum logic [2:0] {
        ST_SW  = 3'b000,
        ST_SB  = 3'b001,
        ST_SH  = 3'b010,
        ST_SWL = 3'b011,
        ST_SWR = 3'b100
    } st_type_e;

    // Request FSM: idle, bus request pending, waiting for write completion.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10
    } state_e;

endpackage

// File: rtl/store_request_unit_align.sv
// Combinational lane mapping of a store: (type, byte offset, rt) -> (strobes, data, errors).
module store_align
    import store_defs::*;
(
    input  logic [2:0]  st_type,
    input  logic [1:0]  a,
    input  logic [31:0] rt,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic        misaligned,
    output logic        type_bad
);

    // Little-endian byte-lane selection per store type and offset.
    always_comb begin
        wstrb      = '0;
        wdata      = '0;
        misaligned = 1'b0;
        type_bad   = 1'b0;
        case (st_type)
            ST_SW: begin
                wstrb      = 4'b1111;
                wdata      = rt;
                misaligned = (a != 2'b00);
            end
            ST_SB: begin
                wstrb = 4'b0001 << a;
                wdata = {4{rt[7:0]}};
            end
            ST_SH: begin
                wstrb      = a[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{rt[15:0]}};
                misaligned = a[0];
            end
            ST_SWL: begin
                case (a)
                    2'd0:    begin wstrb = 4'b0001; wdata = {24'b0, rt[31:24]}; end
                    2'd1:    begin wstrb = 4'b0011; wdata = {16'b0, rt[31:16]}; end
                    2'd2:    begin wstrb = 4'b0111; wdata = {8'b0, rt[31:8]};   end
                    default: begin wstrb = 4'b1111; wdata = rt;                 end
                endcase
            end
            ST_SWR: begin
                case (a)
                    2'd0:    begin wstrb = 4'b1111; wdata = rt;                 end
                    2'd1:    begin wstrb = 4'b1110; wdata = {rt[23:0], 8'b0};   end
                    2'd2:    begin wstrb = 4'b1100; wdata = {rt[15:0], 16'b0};  end
                    default: begin wstrb = 4'b1000; wdata = {rt[7:0], 24'b0};   end
                endcase
            end
            default: begin
                type_bad = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/store_request_unit.sv
// Store request unit: accepts one store, issues one word-aligned strobed write, one outstanding.
module store_request_unit
    import store_defs::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [2:0]        st_type,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_rt_data,
    output logic              st_done,
    output logic              st_ades,
    output logic              data_req,
    output logic              data_wr,
    output logic [ADDR_W-1:0] data_addr,
    output logic [3:0]        data_wstrb,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok
);

    state_e              state_q, state_d;
    logic [ADDR_W-3:0]   addr_q, addr_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                done_q, done_d;
    logic                ades_q, ades_d;

    logic [3:0]          al_wstrb;
    logic [31:0]         al_wdata;
    logic                al_misaligned;
    logic                al_type_bad;

    store_align u_align (
        .st_type    (st_type),
        .a          (st_addr[1:0]),
        .rt         (st_rt_data),
        .wstrb      (al_wstrb),
        .wdata      (al_wdata),
        .misaligned (al_misaligned),
        .type_bad   (al_type_bad)
    );

    // Next-state and register updates; bus fields are captured only on a good accept.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        ades_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (st_valid) begin
                    if (al_misaligned || al_type_bad) begin
                        ades_d = 1'b1;
                    end else begin
                        addr_d  = st_addr[ADDR_W-1:2];
                        wstrb_d = al_wstrb;
                        wdata_d = al_wdata;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (data_addr_ok) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (data_data_ok) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and captured-request registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wstrb_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            ades_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            ades_q  <= ades_d;
        end
    end

    assign st_ready   = (state_q == S_IDLE);
    assign data_req   = (state_q == S_REQ);
    assign data_wr    = data_req;
    assign data_addr  = {addr_q, 2'b00};
    assign data_wstrb = wstrb_q;
    assign data_wdata = wdata_q;
    assign st_done    = done_q;
    assign st_ades    = ades_q;

endmodule

// File: tb/tb_store_request_unit.sv
// Directed self-checking bench for store_request_unit.
module tb_store_request_unit;

    logic        clk;
    logic        resetn;
    logic        st_valid;
    logic        st_ready;
    logic [2:0]  st_type;
    logic [31:0] st_addr;
    logic [31:0] st_rt_data;
    logic        st_done;
    logic        st_ades;
    logic        data_req;
    logic        data_wr;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;

    int unsigned n_total;
    int unsigned n_pass;

    store_request_unit #(.ADDR_W(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .st_valid     (st_valid),
        .st_ready     (st_ready),
        .st_type      (st_type),
        .st_addr      (st_addr),
        .st_rt_data   (st_rt_data),
        .st_done      (st_done),
        .st_ades      (st_ades),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one clock; inputs set afterwards are seen at the next edge, outputs are settled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".ready"}, {31'b0, st_ready}, 32'd1);
        check({tag, ".req"},   {31'b0, data_req}, 32'd0);
        check({tag, ".wr"},    {31'b0, data_wr},  32'd0);
        check({tag, ".done"},  {31'b0, st_done},  32'd0);
        check({tag, ".ades"},  {31'b0, st_ades},  32'd0);
    endtask

    // Full store with addr_ok and data_ok each in the first cycle they can arrive.
    task automatic do_store(input string tag, input logic [2:0] t, input logic [31:0] addr,
                            input logic [31:0] rt, input logic [31:0] exp_addr,
                            input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
        check({tag, ".ready0"}, {31'b0, st_ready}, 32'd1);
        st_valid = 1'b1; st_type = t; st_addr = addr; st_rt_data = rt;
        step();
        st_valid = 1'b0;
        check({tag, ".req"},   {31'b0, data_req}, 32'd1);
        check({tag, ".wr"},    {31'b0, data_wr},  32'd1);
        check({tag, ".ready"}, {31'b0, st_ready}, 32'd0);
        check({tag, ".addr"},  data_addr, exp_addr);
        check({tag, ".strb"},  {28'b0, data_wstrb}, {28'b0, exp_strb});
        check({tag, ".wdata"}, data_wdata, exp_wdata);
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        check({tag, ".wait_req"},   {31'b0, data_req}, 32'd0);
        check({tag, ".wait_ready"}, {31'b0, st_ready}, 32'd0);
        data_data_ok = 1'b1;
        step();
        data_data_ok = 1'b0;
        check({tag, ".done"},  {31'b0, st_done},  32'd1);
        check({tag, ".ready"}, {31'b0, st_ready}, 32'd1);
        check({tag, ".ades"},  {31'b0, st_ades},  32'd0);
        step();
        check({tag, ".done_off"}, {31'b0, st_done}, 32'd0);
    endtask

    // Rejected store: ades pulse for one cycle, no bus request, stays ready.
    task automatic do_bad(input string tag, input logic [2:0] t, input logic [31:0] addr);
        st_valid = 1'b1; st_type = t; st_addr = addr; st_rt_data = 32'hDEADBEEF;
        step();
        st_valid = 1'b0;
        check({tag, ".ades"},  {31'b0, st_ades},  32'd1);
        check({tag, ".done"},  {31'b0, st_done},  32'd0);
        check({tag, ".req"},   {31'b0, data_req}, 32'd0);
        check({tag, ".ready"}, {31'b0, st_ready}, 32'd1);
        step();
        check({tag, ".ades_off"}, {31'b0, st_ades},  32'd0);
        check({tag, ".req2"},     {31'b0, data_req}, 32'd0);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        resetn = 1'b0;
        st_valid = 1'b0; st_type = 3'b000; st_addr = '0; st_rt_data = '0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        step();
        step();
        check_idle_outputs("rst");
        check("rst.addr",  data_addr, 32'h0);
        check("rst.strb",  {28'b0, data_wstrb}, 32'h0);
        check("rst.wdata", data_wdata, 32'h0);
        resetn = 1'b1;
        step();

        do_store("sw",  3'b000, 32'h100, 32'h11223344, 32'h100, 4'b1111, 32'h11223344);

        do_store("sb3", 3'b001, 32'h203, 32'h000000AB, 32'h200, 4'b1000, 32'hABABABAB);
        do_store("sb2", 3'b001, 32'h202, 32'h000000AB, 32'h200, 4'b0100, 32'hABABABAB);
        do_store("sb1", 3'b001, 32'h201, 32'h000000AB, 32'h200, 4'b0010, 32'hABABABAB);
        do_store("sb0", 3'b001, 32'h200, 32'h000000AB, 32'h200, 4'b0001, 32'hABABABAB);

        do_store("sh0", 3'b010, 32'h100, 32'h00001234, 32'h100, 4'b0011, 32'h12341234);
        do_store("sh2", 3'b010, 32'h102, 32'h00001234, 32'h100, 4'b1100, 32'h12341234);

        do_store("swl0", 3'b011, 32'h500, 32'hAABBCCDD, 32'h500, 4'b0001, 32'h000000AA);
        do_store("swl1", 3'b011, 32'h501, 32'hAABBCCDD, 32'h500, 4'b0011, 32'h0000AABB);
        do_store("swl2", 3'b011, 32'h502, 32'hAABBCCDD, 32'h500, 4'b0111, 32'h00AABBCC);
        do_store("swl3", 3'b011, 32'h503, 32'hAABBCCDD, 32'h500, 4'b1111, 32'hAABBCCDD);
        do_store("swr0", 3'b100, 32'h600, 32'hAABBCCDD, 32'h600, 4'b1111, 32'hAABBCCDD);
        do_store("swr1", 3'b100, 32'h601, 32'hAABBCCDD, 32'h600, 4'b1110, 32'hBBCCDD00);
        do_store("swr2", 3'b100, 32'h602, 32'hAABBCCDD, 32'h600, 4'b1100, 32'hCCDD0000);
        do_store("swr3", 3'b100, 32'h603, 32'hAABBCCDD, 32'h600, 4'b1000, 32'hDD000000);

        do_bad("sh_odd",  3'b010, 32'h101);
        do_bad("sw_mis",  3'b000, 32'h102);
        do_bad("bad_typ", 3'b101, 32'h100);

        // Back-pressure: addr_ok withheld for 5 cycles while a second store waits on st_valid.
        st_valid = 1'b1; st_type = 3'b000; st_addr = 32'h300; st_rt_data = 32'hCAFEF00D;
        step();
        st_type = 3'b001; st_addr = 32'h305; st_rt_data = 32'h0000005A;
        for (int i = 0; i < 5; i++) begin
            data_data_ok = (i == 2);
            check($sformatf("bp%0d.req", i),   {31'b0, data_req}, 32'd1);
            check($sformatf("bp%0d.ready", i), {31'b0, st_ready}, 32'd0);
            check($sformatf("bp%0d.addr", i),  data_addr, 32'h300);
            check($sformatf("bp%0d.strb", i),  {28'b0, data_wstrb}, 32'hF);
            check($sformatf("bp%0d.wdata", i), data_wdata, 32'hCAFEF00D);
            check($sformatf("bp%0d.done", i),  {31'b0, st_done}, 32'd0);
            step();
        end
        data_data_ok = 1'b0;
        check("bp.still_req", {31'b0, data_req}, 32'd1);
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        check("bp.wait_ready", {31'b0, st_ready}, 32'd0);
        check("bp.wait_req",   {31'b0, data_req}, 32'd0);
        data_data_ok = 1'b1;
        step();
        data_data_ok = 1'b0;
        check("bp.done",  {31'b0, st_done},  32'd1);
        check("bp.ready", {31'b0, st_ready}, 32'd1);
        step();
        st_valid = 1'b0;
        check("bp2.req",   {31'b0, data_req}, 32'd1);
        check("bp2.addr",  data_addr, 32'h304);
        check("bp2.strb",  {28'b0, data_wstrb}, 32'h2);
        check("bp2.wdata", data_wdata, 32'h5A5A5A5A);
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        step();
        data_data_ok = 1'b0;
        check("bp2.done", {31'b0, st_done}, 32'd1);
        step();

        // Reset during WAIT, then a stray data_ok.
        st_valid = 1'b1; st_type = 3'b000; st_addr = 32'h400; st_rt_data = 32'h55667788;
        step();
        st_valid = 1'b0;
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        check("mr.wait_ready", {31'b0, st_ready}, 32'd0);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        check_idle_outputs("mr");
        check("mr.addr",  data_addr, 32'h0);
        check("mr.strb",  {28'b0, data_wstrb}, 32'h0);
        check("mr.wdata", data_wdata, 32'h0);
        data_data_ok = 1'b1;
        step();
        data_data_ok = 1'b0;
        check_idle_outputs("mr_stray");
        step();
        check("mr_stray.done2", {31'b0, st_done}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/store_request_unit.md
# store_request_unit

Store-side counterpart of the writeback load extractor: accepts one store per handshake from the execute stage and turns it into a byte-strobed, word-aligned write on the data-memory request bus. Handles SW, SB, SH, SWL and SWR, detects misaligned SH/SW, and keeps exactly one transaction outstanding. It sits between the execute stage and the data SRAM-like bus, and back-pressures the pipeline through `st_ready`.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.

Ports:
- `clk` in 1: clock.
- `resetn` in 1: synchronous, active-low reset.
- `st_valid` in 1: a store is presented.
- `st_ready` out 1: block can accept a store this cycle.
- `st_type` in 3: store type, encoded SW=000, SB=001, SH=010, SWL=011, SWR=100.
- `st_addr` in ADDR_W: byte address.
- `st_rt_data` in 32: rt register value.
- `st_done` out 1: one-cycle pulse when the write completes (`data_data_ok`).
- `st_ades` out 1: one-cycle pulse flagging a misaligned SH/SW, or an undefined `st_type`.
- `data_req` out 1: bus request.
- `data_wr` out 1: constant 1 while `data_req` is high.
- `data_addr` out ADDR_W: `{addr[ADDR_W-1:2], 2'b00}`.
- `data_wstrb` out 4: byte enables.
- `data_wdata` out 32: lane-aligned write data.
- `data_addr_ok` in 1: bus accepted the request.
- `data_data_ok` in 1: write completed.

## Operation
- FSM states and transitions:
  - IDLE to REQ on `st_valid & st_ready & aligned & type_defined`.
  - REQ to WAIT on `data_addr_ok`.
  - WAIT to IDLE on `data_data_ok`.
- `st_ready` is 1 only in IDLE.
- On accept, the block latches `addr[ADDR_W-1:2]`, `wstrb` and `wdata`. Bus outputs are driven from these registers and stay stable throughout REQ.
- `data_req` is 1 only in REQ.
- Lane mapping is little-endian, with `a = st_addr[1:0]`:
  - SW: wstrb 1111, data rt. Requires a=00.
  - SB: wstrb `4'b0001 << a`, data `{4{rt[7:0]}}`.
  - SH: a=00 gives 0011; a=10 gives 1100. Data `{2{rt[15:0]}}`. Odd `a` is misaligned.
  - SWL:
    - a=00: 0001, `{24'b0, rt[31:24]}`
    - a=01: 0011, `{16'b0, rt[31:16]}`
    - a=10: 0111, `{8'b0, rt[31:8]}`
    - a=11: 1111, rt
  - SWR:
    - a=00: 1111, rt
    - a=01: 1110, `{rt[23:0], 8'b0}`
    - a=10: 1100, `{rt[15:0], 16'b0}`
    - a=11: 1000, `{rt[7:0], 24'b0}`
- A misaligned store or undefined type presented in IDLE:
  - `st_ades` is 1 in the next cycle.
  - No bus request is issued, and the block stays in IDLE.
  - The store counts as consumed (`st_ready` was 1).
- `data_data_ok` seen in IDLE or REQ is ignored (protocol violation, no state change).
- `data_addr_ok` outside REQ is ignored.

## Timing
- Reset values: state IDLE; `st_ready`=1; `st_done`, `st_ades`, `data_req`, `data_wr` = 0; `data_addr`, `data_wstrb`, `data_wdata` = 0.
- Reset mid-transaction returns the block to IDLE the next cycle. Any late `data_data_ok` is then ignored.
- Latency:
  - Store accepted at cycle t gives `data_req`=1 from t+1.
  - `data_addr_ok` at cycle u gives WAIT from u+1.
  - `data_data_ok` at cycle v gives `st_done`=1 at v+1 and IDLE (`st_ready`=1) at v+1.
- Back-to-back stores: minimum 3 cycles per store when `addr_ok` and `data_ok` each come in the first cycle they can.
- `st_done` and `st_ades` are registered, single-cycle, and never high together.

## Structure
- Shared package `store_defs`: store-type constants (SW/SB/SH/SWL/SWR) and FSM state encoding (IDLE/REQ/WAIT). These sit alongside the existing load-type constants.
- One natural sub-module, `store_align`: purely combinational mapping of (type, a, rt) to (wstrb, wdata, misaligned). The top level holds the FSM and registers.

## Test plan
- SW, addr 0x100, rt 0x11223344, `addr_ok` at the first REQ cycle, `data_ok` one cycle later -> addr 0x100, wstrb 1111, wdata 0x11223344, `st_done` pulse, `st_ready` back after 3 cycles.
- SB at each of 0x203..0x200, rt 0xAB -> wstrb 1000/0100/0010/0001, wdata 0xABABABAB, addr 0x200.
- SWL/SWR sweep of `a`=0..3 with rt 0xAABBCCDD -> e.g. SWL a=01 gives 0011/0x0000AABB; SWR a=11 gives 1000/0xDD000000.
- SH at 0x101 -> `st_ades`=1 for one cycle, no `data_req`, `st_ready` stays 1; SW at 0x102 behaves the same.
- `addr_ok` held low for 5 cycles with `st_valid` continuously high -> `data_req` and bus fields stable, `st_ready`=0 throughout, second store accepted only after `data_ok`.
- `resetn` low during WAIT, then a stray `data_data_ok` -> IDLE, no `st_done`, all outputs at reset values.
